// File: rtl/booth_divider_path.sv
`default_nettype none
// ============================================================================
// Module   : booth_divider_path
// Brief    : Sequential signed restoring divider, one quotient bit per cycle.
//            Optional macro DIV_ZERO_CHECK_EN short-circuits a zero divisor.
// Revision : 1.0 - initial release
// ============================================================================
module booth_divider_path #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [WIDTH-1:0]   c_MIN_MAG  = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_LOAD_DVSR = 3'd1;
    localparam logic [2:0] c_ST_DIVIDE    = 3'd2;
    localparam logic [2:0] c_ST_FIXUP     = 3'd3;
    localparam logic [2:0] c_ST_DONE      = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_q;          // dividend magnitude, shifted out as quotient shifts in
    logic [WIDTH:0]     r_prem;
    logic [WIDTH-1:0]   r_dvsr_mag;
    logic               r_dvd_neg;
    logic               r_dvsr_neg;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_overflow;

    logic [WIDTH-1:0]   w_mag;
    logic [WIDTH+1:0]   w_shift;
    logic [WIDTH+1:0]   w_diff;

    assign w_mag   = data_in[WIDTH-1] ? ({WIDTH{1'b0}} - data_in) : data_in;
    assign w_shift = {r_prem, r_q[WIDTH-1]};
    assign w_diff  = w_shift - {2'b00, r_dvsr_mag};

`ifdef DIV_ZERO_CHECK_EN
    logic w_dvsr_zero;
    logic r_div_by_zero;
    assign w_dvsr_zero = (data_in == {WIDTH{1'b0}});
    assign div_by_zero = r_div_by_zero;
`else
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:      if (start) w_next_state = c_ST_LOAD_DVSR;
`ifdef DIV_ZERO_CHECK_EN
            c_ST_LOAD_DVSR: w_next_state = w_dvsr_zero ? c_ST_DONE : c_ST_DIVIDE;
`else
            c_ST_LOAD_DVSR: w_next_state = c_ST_DIVIDE;
`endif
            c_ST_DIVIDE:    if (r_cnt == c_CNT_ONE) w_next_state = c_ST_FIXUP;
            c_ST_FIXUP:     w_next_state = c_ST_DONE;
            c_ST_DONE:      w_next_state = c_ST_IDLE;
            default:        w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_cnt       <= '0;
            r_q         <= '0;
            r_prem      <= '0;
            r_dvsr_mag  <= '0;
            r_dvd_neg   <= 1'b0;
            r_dvsr_neg  <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_overflow  <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
            r_div_by_zero <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_q        <= w_mag;
                        r_dvd_neg  <= data_in[WIDTH-1];
                        r_overflow <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
                        r_div_by_zero <= 1'b0;
`endif
                    end
                end
                c_ST_LOAD_DVSR: begin
                    r_dvsr_mag <= w_mag;
                    r_dvsr_neg <= data_in[WIDTH-1];
                    r_cnt      <= c_CNT_LOAD;
                    r_prem     <= '0;
`ifdef DIV_ZERO_CHECK_EN
                    if (w_dvsr_zero) begin
                        r_quotient    <= '1;
                        r_remainder   <= r_dvd_neg ? ({WIDTH{1'b0}} - r_q) : r_q;
                        r_div_by_zero <= 1'b1;
                    end
`endif
                end
                c_ST_DIVIDE: begin
                    if (!w_diff[WIDTH+1]) begin
                        r_prem <= w_diff[WIDTH:0];
                        r_q    <= {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_prem <= w_shift[WIDTH:0];
                        r_q    <= {r_q[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - c_CNT_ONE;
                end
                c_ST_FIXUP: begin
                    r_quotient  <= (r_dvd_neg ^ r_dvsr_neg) ? ({WIDTH{1'b0}} - r_q) : r_q;
                    r_remainder <= r_dvd_neg ? ({WIDTH{1'b0}} - r_prem[WIDTH-1:0])
                                             : r_prem[WIDTH-1:0];
                    // A magnitude of 2^(WIDTH-1) with like signs only arises from MIN / -1
                    r_overflow  <= !(r_dvd_neg ^ r_dvsr_neg) && (r_q == c_MIN_MAG);
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != c_ST_IDLE);
    assign done      = (r_state == c_ST_DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_booth_divider_path.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_divider_path
// Brief    : Directed self-checking bench with an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_divider_path;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             clear;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             overflow;
    logic             div_by_zero;

    int checks = 0;
    int errors = 0;
    logic run_chk = 1'b0;

    booth_divider_path #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .clear      (clear),
        .start      (start),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .overflow   (overflow),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle index since accepted start, results from plain arithmetic
    int               m_cyc = 0;
    int               m_lat = WIDTH + 3;
    logic [WIDTH-1:0] m_dvd = '0;
    logic [WIDTH-1:0] m_q = '0;
    logic [WIDTH-1:0] m_r = '0;
    logic             m_ov = 1'b0;
    logic             m_dz = 1'b0;
    int               m_a, m_b, m_qi, m_ri;

    always @(posedge clk) begin
        if (clear) begin
            m_cyc = 0; m_q = '0; m_r = '0; m_ov = 1'b0; m_dz = 1'b0;
        end else if (m_cyc == 0) begin
            if (start) begin
                m_dvd = data_in; m_cyc = 1; m_lat = WIDTH + 3; m_ov = 1'b0; m_dz = 1'b0;
            end
        end else begin
            if (m_cyc == 1) begin
                m_a = $signed(m_dvd);
                m_b = $signed(data_in);
                if (m_b == 0) begin
                    m_r = m_dvd;
`ifdef DIV_ZERO_CHECK_EN
                    m_q = '1; m_dz = 1'b1; m_lat = 2;
`else
                    m_q = (m_a < 0) ? WIDTH'(1) : '1;
`endif
                end else begin
                    m_qi = m_a / m_b;
                    m_ri = m_a % m_b;
                    m_q  = m_qi[WIDTH-1:0];
                    m_r  = m_ri[WIDTH-1:0];
                    m_ov = (m_a == -(1 << (WIDTH-1))) && (m_b == -1);
                end
            end
            if (m_cyc == m_lat) m_cyc = 0;
            else m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            chk("m_busy", busy, m_cyc != 0);
            chk("m_done", done, (m_cyc != 0) && (m_cyc == m_lat));
            if (m_cyc == 0 || m_cyc == m_lat) begin
                chk("m_quotient", quotient, m_q);
                chk("m_remainder", remainder, m_r);
                chk("m_overflow", overflow, m_ov);
                chk("m_div_by_zero", div_by_zero, m_dz);
            end
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                          input logic eov, input logic edz, input int elat);
        int cyc;
        logic got;
        @(posedge clk); #1 start = 1'b1; data_in = a;
        @(posedge clk); #1 start = 1'b0; data_in = b;
        cyc = 1; got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else begin
                @(posedge clk); #1 data_in = 8'hA5;
                cyc++;
            end
        end
        chk("latency", cyc, elat);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("overflow", overflow, eov);
        chk("div_by_zero", div_by_zero, edz);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        clear = 1'b1; start = 1'b0; data_in = '0;
        @(posedge clk); #1 run_chk = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_quotient", quotient, 0);

        run_op(8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 11);
        run_op(8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 1'b0, 11);
        run_op(8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 11);
        run_op(8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, 11);
        run_op(8'h80, 8'hFF, 8'h80, 8'h00, 1'b1, 1'b0, 11);
        run_op(8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 11);
`ifdef DIV_ZERO_CHECK_EN
        run_op(8'h25, 8'h00, 8'hFF, 8'h25, 1'b0, 1'b1, 2);
        run_op(8'hDB, 8'h00, 8'hFF, 8'hDB, 1'b0, 1'b1, 2);
`else
        run_op(8'h25, 8'h00, 8'hFF, 8'h25, 1'b0, 1'b0, 11);
        run_op(8'hDB, 8'h00, 8'h01, 8'hDB, 1'b0, 1'b0, 11);
`endif
        run_op(8'd5, 8'd9, 8'h00, 8'h05, 1'b0, 1'b0, 11);
        run_op(8'd0, 8'd3, 8'h00, 8'h00, 1'b0, 1'b0, 11);

        // start presented during the DONE cycle must be ignored
        start = 1'b1; data_in = 8'h33;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("done_start_ignored", busy, 0);
        repeat (3) @(posedge clk);

        // restart attempt at cycle 5, clear at cycle 6
        @(posedge clk); #1 start = 1'b1; data_in = 8'd100;
        @(posedge clk); #1 start = 1'b0; data_in = 8'd7;
        repeat (3) @(posedge clk);
        #1 start = 1'b1; data_in = 8'h11;
        @(posedge clk); #1 start = 1'b0; clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        chk("clr_quotient", quotient, 0);
        chk("clr_remainder", remainder, 0);
        chk("clr_overflow", overflow, 0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk("clr_no_done", done, 0);
        end
        run_op(8'd50, 8'd5, 8'h0A, 8'h00, 1'b0, 1'b0, 11);

        repeat (4) @(posedge clk);
        @(negedge clk);
        run_chk = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/booth_divider_path.md
Name: booth_divider_path

Overview:
- Sequential signed two's-complement divider; the inverse companion to the multiplier datapath in the arithmetic unit.
- Operands arrive over the same shared data_in bus: dividend first, divisor on the next cycle.
- Computes the quotient and remainder by sign-magnitude restoring division, one bit per cycle, under an internal FSM with a start/done handshake.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits

Ports:
clk  input  1  rising-edge clock; the only clock
clear  input  1  synchronous active-high reset
start  input  1  begin operation; dividend is on data_in in the same cycle
data_in  input  WIDTH  operand bus; dividend in the start cycle, divisor in the next cycle
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; results are valid from this cycle
quotient  output  WIDTH  signed quotient, truncated toward zero
remainder  output  WIDTH  signed remainder; its sign follows the dividend
overflow  output  1  set for the most-negative value divided by -1
div_by_zero  output  1  divisor was zero (only with the optional feature)

Behaviour:
- Reset: clear=1 at a clock edge forces IDLE. busy, done, quotient, remainder, overflow and div_by_zero all go to 0. Counter and internal registers are zeroed. Clear takes priority over every other input, including mid-operation.
- FSM states: IDLE, LOAD_DVSR, DIVIDE, FIXUP, DONE.
- IDLE: start=1 captures the dividend magnitude and its sign from data_in, clears overflow and div_by_zero, then goes to LOAD_DVSR. start=0 holds the state.
- LOAD_DVSR: captures the divisor magnitude and its sign from data_in. Loads the counter with WIDTH. Clears the WIDTH+1 bit partial remainder. Next state is DIVIDE.
  - Magnitude of the most-negative value is 2^(WIDTH-1); it fits in WIDTH unsigned bits.
- DIVIDE, one iteration per cycle:
  - Shift the dividend MSB into the partial remainder.
  - Trial-subtract the divisor magnitude.
  - If the result is non-negative, keep the difference and shift 1 into the quotient; otherwise restore and shift 0.
  - Decrement the counter. When it reaches zero, go to FIXUP.
  - This state runs exactly WIDTH cycles.
- FIXUP:
  - Negate the quotient if the dividend sign XOR the divisor sign is 1.
  - Negate the remainder if the dividend was negative.
  - Set overflow if the dividend is the most-negative value and the divisor is -1; the quotient then wraps to the most-negative value.
  - Next state is DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- Output holding: quotient, remainder and the flags hold their values until the next accepted start or clear.
- Latency: with start accepted at cycle 0, done=1 at cycle WIDTH+3 (cycle 11 for WIDTH=8).
- busy is high from cycle 1 through the DONE cycle, inclusive.
- start is ignored whenever the FSM is not in IDLE. A start in the DONE cycle is ignored; back-to-back operations need one idle cycle.
- quotient and remainder only update in FIXUP. They are not required to hold intermediate values, but must be stable and correct while done=1.

Optional Feature:
Macro DIV_ZERO_CHECK_EN.
- Defined:
  - A zero divisor in LOAD_DVSR jumps directly to DONE, so done arrives at cycle 2.
  - quotient is all ones, remainder equals the dividend, div_by_zero=1, overflow=0.
- Undefined:
  - div_by_zero is tied to 0 and a zero divisor runs the normal path.
  - Result: quotient is all ones for a non-negative dividend, 1 for a negative dividend. remainder equals the dividend. Latency is WIDTH+3.

Test Plan:
1. Dividend 100, divisor 7, WIDTH=8 -> quotient 0x0E, remainder 0x02, overflow 0, done at cycle 11, busy high cycles 1-11.
2. Signs, one case at a time:
   - -100/7 -> quotient 0xF2, remainder 0xFE.
   - 100/-7 -> quotient 0xF2, remainder 0x02.
   - -100/-7 -> quotient 0x0E, remainder 0xFE.
3. -128/-1 -> quotient 0x80, remainder 0x00, overflow 1. Also -128/1 -> quotient 0x80, overflow 0.
4. 37/0 with DIV_ZERO_CHECK_EN -> done at cycle 2, quotient 0xFF, remainder 0x25, div_by_zero 1. Same stimulus without the macro -> done at cycle 11, quotient 0xFF, remainder 0x25.
5. Start 100/7, assert start again at cycle 5 -> ignored, result unchanged. Assert clear at cycle 6 -> next cycle is IDLE, all outputs 0, no done pulse. A new 50/5 then yields quotient 0x0A, remainder 0x00.
6. 5/9 and 0/3 -> quotient 0x00 with remainder 0x05, and quotient 0x00 with remainder 0x00.
